// File: rtl/fetch_ifid_stage_if.sv
// Bundle between the fetch stage, instruction memory, hazard detector and decode.
// master = fetch stage side, slave = everything around it.
interface fetch_ifid_stage_if;
  logic        PCWrite;
  logic        IF_IDWrite;
  logic        Branch_taken;
  logic [31:0] Branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;

  modport master (
    input  PCWrite, IF_IDWrite, Branch_taken, Branch_target, imem_rdata, imem_ack,
    output imem_req, imem_addr, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, IF_ID_Rs, IF_ID_Rt
  );

  modport slave (
    output PCWrite, IF_IDWrite, Branch_taken, Branch_target, imem_rdata, imem_ack,
    input  imem_req, imem_addr, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, IF_ID_Rs, IF_ID_Rt
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch with req/ack memory handshake and IF/ID register.
// HOLD parks a word fetched during a stall; DRAIN retires a request made stale by a redirect.
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  fetch_ifid_stage_if.master bus
);
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_instr, r_pc4, r_hold_instr, r_hold_pc4, r_redir;
  logic        r_valid;
  logic [31:0] w_target, w_pc4;
  logic        w_go;

  assign w_target = bus.Branch_target & ~32'h3;
  assign w_pc4    = r_pc + 32'd4;
  assign w_go     = bus.PCWrite & bus.IF_IDWrite;

  assign bus.imem_req    = (r_state != S_HOLD) & ~reset;
  assign bus.imem_addr   = r_pc;
  assign bus.IF_ID_Instr = r_instr;
  assign bus.IF_ID_PC4   = r_pc4;
  assign bus.IF_ID_Valid = r_valid;
  assign bus.IF_ID_Rs    = r_instr[25:21];
  assign bus.IF_ID_Rt    = r_instr[20:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc4        <= 32'h0;
      r_valid      <= 1'b0;
      r_hold_instr <= 32'h0;
      r_hold_pc4   <= 32'h0;
      r_redir      <= 32'h0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (bus.Branch_taken) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            if (bus.imem_ack) begin
              r_pc <= w_target;
            end else begin
              // request already on the bus must finish before redirecting
              r_redir <= w_target;
              r_state <= S_DRAIN;
            end
          end else if (bus.imem_ack) begin
            if (w_go) begin
              r_instr <= bus.imem_rdata;
              r_pc4   <= w_pc4;
              r_valid <= 1'b1;
              r_pc    <= w_pc4;
            end else begin
              r_hold_instr <= bus.imem_rdata;
              r_hold_pc4   <= w_pc4;
              r_state      <= S_HOLD;
            end
          end else if (bus.IF_IDWrite) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (bus.Branch_taken) begin
            r_pc    <= w_target;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_state <= S_REQ;
          end else if (w_go) begin
            r_instr <= r_hold_instr;
            r_pc4   <= r_hold_pc4;
            r_valid <= 1'b1;
            r_pc    <= w_pc4;
            r_state <= S_REQ;
          end
        end
        S_DRAIN: begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
          if (bus.imem_ack) begin
            r_pc    <= bus.Branch_taken ? w_target : r_redir;
            r_state <= S_REQ;
          end else if (bus.Branch_taken) begin
            r_redir <= w_target;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end
endmodule
